// File: rtl/imm_extend_pipe_if.sv
// Valid/ready instruction-in / immediate-out bundle for imm_extend_pipe.
// master = producer/consumer side, slave = the immediate generator.
interface imm_extend_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [2:0]      ImmSrc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_type;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, ImmSrc, out_ready,
    input  in_ready, out_valid, out_imm, out_type, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, ImmSrc, out_ready,
    output in_ready, out_valid, out_imm, out_type, out_illegal
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Registered RISC-V immediate generator with a 2-entry skid buffer, flush,
// optional opcode-based type decode and a saturating illegal-format counter.
module imm_extend_pipe #(
  parameter int XLEN        = 32,
  parameter int AUTO_DECODE = 0,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  imm_extend_pipe_if.slave     bus,
  output logic [CNT_W-1:0]     illegal_cnt
);

  localparam logic [2:0] T_I    = 3'b000;
  localparam logic [2:0] T_S    = 3'b001;
  localparam logic [2:0] T_B    = 3'b010;
  localparam logic [2:0] T_J    = 3'b011;
  localparam logic [2:0] T_U    = 3'b100;
  localparam logic [2:0] T_Z    = 3'b101;
  localparam logic [2:0] T_ILL  = 3'b111;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  function automatic logic [2:0] decode_type(input logic [31:0] instr);
    case (instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011: return T_I;
      7'b0100011:                                     return T_S;
      7'b1100011:                                     return T_B;
      7'b1101111:                                     return T_J;
      7'b0110111, 7'b0010111:                         return T_U;
      7'b1110011:                                     return instr[14] ? T_Z : T_I;
      default:                                        return T_ILL;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [2:0] typ);
    return (typ == 3'b110) || (typ == 3'b111);
  endfunction

  // Every format is first built as a signed 32-bit value; the size cast then
  // sign-extends it to XLEN (zimm has bit 31 clear, so it zero-extends).
  function automatic logic signed [XLEN-1:0] extend(input logic [31:0] instr,
                                                    input logic [2:0]  typ);
    logic signed [31:0] v;
    v = '0;
    case (typ)
      T_I: v = {{20{instr[31]}}, instr[31:20]};
      T_S: v = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      T_B: v = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      T_J: v = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      T_U: v = {instr[31:12], 12'b0};
      T_Z: v = {27'b0, instr[19:15]};
      default: v = '0;
    endcase
    return XLEN'(v);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

  // ---- stage p0: combinational extension at the input ----
  logic [2:0]             dec_type_p0;
  logic [2:0]             in_type_p0;
  logic                   in_ill_p0;
  logic signed [XLEN-1:0] in_imm_p0;

  assign dec_type_p0 = decode_type(bus.in_instr);
  assign in_type_p0  = (AUTO_DECODE != 0) ? dec_type_p0 : bus.ImmSrc;
  assign in_ill_p0   = is_illegal(in_type_p0);
  assign in_imm_p0   = extend(bus.in_instr, in_type_p0);

  // ---- stage p1: head/skid buffer ----
  state_t                 state_q, state_d;
  logic                   rdy_q;
  logic                   vld_p1;
  logic                   accept, rel;
  logic                   load_head, load_skid, move_skid;
  logic [CNT_W-1:0]       cnt_q;

  logic signed [XLEN-1:0] head_imm_p1, skid_imm_p1;
  logic [2:0]             head_type_p1, skid_type_p1;
  logic                   head_ill_p1, skid_ill_p1;

  assign vld_p1 = (state_q != EMPTY);
  assign accept = bus.in_valid & rdy_q & ~flush;
  assign rel    = vld_p1 & bus.out_ready;

  always_comb begin
    state_d   = state_q;
    load_head = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = ONE;
            load_head = 1'b1;
          end
        end
        ONE: begin
          if (accept && rel) begin
            load_head = 1'b1;
          end else if (accept) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (rel) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (rel) begin
            state_d   = ONE;
            move_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != FULL);
      if (accept && in_ill_p0) begin
        cnt_q <= sat_inc(cnt_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_imm_p1  <= '0;
      head_type_p1 <= '0;
      head_ill_p1  <= 1'b0;
    end else if (load_head) begin
      head_imm_p1  <= in_imm_p0;
      head_type_p1 <= in_type_p0;
      head_ill_p1  <= in_ill_p0;
    end else if (move_skid) begin
      head_imm_p1  <= skid_imm_p1;
      head_type_p1 <= skid_type_p1;
      head_ill_p1  <= skid_ill_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_imm_p1  <= in_imm_p0;
      skid_type_p1 <= in_type_p0;
      skid_ill_p1  <= in_ill_p0;
    end
  end

  assign bus.in_ready    = rdy_q;
  assign bus.out_valid   = vld_p1;
  assign bus.out_imm     = head_imm_p1;
  assign bus.out_type    = head_type_p1;
  assign bus.out_illegal = head_ill_p1;
  assign illegal_cnt     = cnt_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: one ImmSrc-driven XLEN=32 instance
// (CNT_W=2) and one auto-decoding XLEN=64 instance.
module tb_imm_extend_pipe;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  typ;
    logic        ill;
    logic        chk_typ;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush_a, flush_b;
  logic [1:0] cnt_a;
  logic [7:0] cnt_b;
  int         tests = 0;
  int         fails = 0;

  exp_t nxt_a, nxt_b, ea, eb;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  imm_extend_pipe_if #(.XLEN(32)) ifa();
  imm_extend_pipe_if #(.XLEN(64)) ifb();

  imm_extend_pipe #(.XLEN(32), .AUTO_DECODE(0), .CNT_W(2)) dut_a (
    .clk(clk), .reset(rst), .flush(flush_a), .bus(ifa.slave), .illegal_cnt(cnt_a)
  );

  imm_extend_pipe #(.XLEN(64), .AUTO_DECODE(1), .CNT_W(8)) dut_b (
    .clk(clk), .reset(rst), .flush(flush_b), .bus(ifb.slave), .illegal_cnt(cnt_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue side: record the expectation of every accepted instruction.
  always @(negedge clk) begin
    if (rst || flush_a) qa.delete();
    else if (ifa.in_valid && ifa.in_ready) qa.push_back(nxt_a);
    if (rst || flush_b) qb.delete();
    else if (ifb.in_valid && ifb.in_ready) qb.push_back(nxt_b);
  end

  // Output side: compare each released result against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && ifa.out_valid && ifa.out_ready) begin
      if (qa.size() == 0) begin
        tests++; fails++;
        $display("FAIL a_unexpected: got output %h, expected no output", ifa.out_imm);
      end else begin
        ea = qa.pop_front();
        check("a_imm", 64'(ifa.out_imm), ea.imm);
        check("a_illegal", 64'(ifa.out_illegal), 64'(ea.ill));
        if (ea.chk_typ) check("a_type", 64'(ifa.out_type), 64'(ea.typ));
      end
    end
    if (!rst && ifb.out_valid && ifb.out_ready) begin
      if (qb.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_unexpected: got output %h, expected no output", ifb.out_imm);
      end else begin
        eb = qb.pop_front();
        check("b_imm", ifb.out_imm, eb.imm);
        check("b_illegal", 64'(ifb.out_illegal), 64'(eb.ill));
        if (eb.chk_typ) check("b_type", 64'(ifb.out_type), 64'(eb.typ));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_a(input logic [31:0] instr, input logic [2:0] src,
                         input logic [63:0] imm, input logic [2:0] typ, input logic ill);
    ifa.in_valid = 1'b1;
    ifa.in_instr = instr;
    ifa.ImmSrc   = src;
    nxt_a        = '{imm, typ, ill, 1'b1};
    tick();
    ifa.in_valid = 1'b0;
  endtask

  task automatic drive_b(input logic [31:0] instr, input logic [63:0] imm,
                         input logic [2:0] typ, input logic ill);
    ifb.in_valid = 1'b1;
    ifb.in_instr = instr;
    ifb.ImmSrc   = 3'b110;
    nxt_b        = '{imm, typ, ill, !ill};
    tick();
    ifb.in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush_a = 1'b0; flush_b = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_instr = '0; ifa.ImmSrc = '0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_instr = '0; ifb.ImmSrc = '0; ifb.out_ready = 1'b0;
    nxt_a = '0; nxt_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_a_valid", 64'(ifa.out_valid), 64'd0);
    check("rst_a_imm", 64'(ifa.out_imm), 64'd0);
    check("rst_a_type", 64'(ifa.out_type), 64'd0);
    check("rst_a_illegal", 64'(ifa.out_illegal), 64'd0);
    check("rst_a_cnt", 64'(cnt_a), 64'd0);
    check("rst_a_ready", 64'(ifa.in_ready), 64'd1);
    check("rst_b_valid", 64'(ifb.out_valid), 64'd0);
    check("rst_b_cnt", 64'(cnt_b), 64'd0);
    check("rst_b_ready", 64'(ifb.in_ready), 64'd1);

    // Auto decode, XLEN=64 (ImmSrc held at an illegal code to show it is ignored)
    ifb.out_ready = 1'b1;
    drive_b(32'h123452B7, 64'h0000000012345000, 3'b100, 1'b0);
    drive_b(32'h800002B7, 64'hFFFFFFFF80000000, 3'b100, 1'b0);
    drive_b(32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'b000, 1'b0);
    drive_b(32'hFE112E23, 64'hFFFFFFFFFFFFFFFC, 3'b001, 1'b0);
    drive_b(32'hFE000CE3, 64'hFFFFFFFFFFFFFFF8, 3'b010, 1'b0);
    drive_b(32'h001000EF, 64'h0000000000000800, 3'b011, 1'b0);
    drive_b(32'h000FD073, 64'h000000000000001F, 3'b101, 1'b0);
    drive_b(32'h30002573, 64'h0000000000000300, 3'b000, 1'b0);
    drive_b(32'h00000000, 64'h0, 3'b111, 1'b1);
    tick(); tick();
    check("b_cnt_after_illegal", 64'(cnt_b), 64'd1);
    check("b_drained", 64'(qb.size()), 64'd0);

    // ImmSrc path, XLEN=32
    ifa.out_ready = 1'b1;
    drive_a(32'hFFF00093, 3'b000, 64'hFFFFFFFF, 3'b000, 1'b0);
    check("a_latency_valid", 64'(ifa.out_valid), 64'd1);
    check("a_latency_imm", 64'(ifa.out_imm), 64'hFFFFFFFF);
    drive_a(32'hFE112E23, 3'b001, 64'hFFFFFFFC, 3'b001, 1'b0);
    drive_a(32'hFE000CE3, 3'b010, 64'hFFFFFFF8, 3'b010, 1'b0);
    drive_a(32'h001000EF, 3'b011, 64'h00000800, 3'b011, 1'b0);
    drive_a(32'h0000D073, 3'b101, 64'h00000001, 3'b101, 1'b0);
    drive_a(32'h000FD073, 3'b101, 64'h0000001F, 3'b101, 1'b0);
    drive_a(32'h123452B7, 3'b100, 64'h12345000, 3'b100, 1'b0);
    drive_a(32'h00500093, 3'b000, 64'h00000005, 3'b000, 1'b0);
    drive_a(32'h00500093, 3'b110, 64'h0, 3'b110, 1'b1);
    tick(); tick();
    check("a_cnt_one", 64'(cnt_a), 64'd1);

    // Backpressure: four offered, two accepted
    ifa.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ifa.in_valid = 1'b1;
      ifa.in_instr = {12'(k + 1), 20'h00093};
      ifa.ImmSrc   = 3'b000;
      nxt_a        = '{64'(k + 1), 3'b000, 1'b0, 1'b1};
      tick();
      check("a_bp_ready", 64'(ifa.in_ready), (k == 0) ? 64'd1 : 64'd0);
    end
    ifa.in_valid = 1'b0;
    tick();
    check("a_bp_hold_valid", 64'(ifa.out_valid), 64'd1);
    check("a_bp_hold_imm", 64'(ifa.out_imm), 64'd1);
    ifa.out_ready = 1'b1;
    tick();
    check("a_bp_second_valid", 64'(ifa.out_valid), 64'd1);
    check("a_bp_second_imm", 64'(ifa.out_imm), 64'd2);
    tick();
    check("a_bp_empty", 64'(ifa.out_valid), 64'd0);

    // Accept plus release in ONE: no bubbles
    for (int k = 0; k < 4; k++) begin
      drive_a({12'(k + 5), 20'h00093}, 3'b000, 64'(k + 5), 3'b000, 1'b0);
      check("a_stream_valid", 64'(ifa.out_valid), 64'd1);
      check("a_stream_ready", 64'(ifa.in_ready), 64'd1);
      check("a_stream_head", 64'(ifa.out_imm), 64'(k + 5));
    end
    tick();

    // Flush while FULL with an instruction offered
    ifa.out_ready = 1'b0;
    drive_a(32'h00100093, 3'b000, 64'd1, 3'b000, 1'b0);
    drive_a(32'h00200093, 3'b000, 64'd2, 3'b000, 1'b0);
    check("a_full_ready", 64'(ifa.in_ready), 64'd0);
    flush_a = 1'b1;
    ifa.in_valid = 1'b1; ifa.in_instr = 32'h00300093; ifa.ImmSrc = 3'b000;
    tick();
    flush_a = 1'b0; ifa.in_valid = 1'b0;
    check("a_flush_full_valid", 64'(ifa.out_valid), 64'd0);
    check("a_flush_full_ready", 64'(ifa.in_ready), 64'd1);

    // Flush while ONE with an illegal instruction offered
    drive_a(32'h00100093, 3'b000, 64'd1, 3'b000, 1'b0);
    flush_a = 1'b1;
    ifa.in_valid = 1'b1; ifa.in_instr = 32'h00500093; ifa.ImmSrc = 3'b110;
    #1 check("a_flush_one_ready", 64'(ifa.in_ready), 64'd1);
    @(posedge clk); #1;
    flush_a = 1'b0; ifa.in_valid = 1'b0;
    check("a_flush_one_valid", 64'(ifa.out_valid), 64'd0);
    check("a_flush_cnt", 64'(cnt_a), 64'd1);
    tick();
    check("a_flush_not_taken", 64'(ifa.out_valid), 64'd0);
    ifa.out_ready = 1'b1;
    drive_a(32'h00300093, 3'b000, 64'd3, 3'b000, 1'b0);
    check("a_after_flush_imm", 64'(ifa.out_imm), 64'd3);
    tick();

    // Counter saturation with CNT_W=2
    rst = 1'b1; tick(); rst = 1'b0;
    check("sat_cnt_reset", 64'(cnt_a), 64'd0);
    for (int k = 0; k < 5; k++) begin
      drive_a(32'h00000000, 3'b111, 64'h0, 3'b111, 1'b1);
    end
    tick();
    check("sat_cnt", 64'(cnt_a), 64'd3);
    drive_a(32'h00000000, 3'b110, 64'h0, 3'b110, 1'b1);
    drive_a(32'hFFF00093, 3'b000, 64'hFFFFFFFF, 3'b000, 1'b0);
    ifa.out_ready = 1'b0;
    drive_a(32'h00100093, 3'b000, 64'd1, 3'b000, 1'b0);
    check("sat_cnt_hold", 64'(cnt_a), 64'd3);
    rst = 1'b1; tick(); rst = 1'b0;
    check("reset_mid_cnt", 64'(cnt_a), 64'd0);
    check("reset_mid_valid", 64'(ifa.out_valid), 64'd0);
    check("reset_mid_imm", 64'(ifa.out_imm), 64'd0);
    tick();
    check("a_drained", 64'(qa.size()), 64'd0);
    check("b_drained_end", 64'(qb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
